// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer: DEPTH-entry valid/ready elastic buffer with
// first-word fall-through (1-cycle latency), occupancy count and an
// almost-full flag. s_ready is decoded from registered count only, so it
// has no combinational path from m_ready.
// Optional feature: define HS_BUF_FLUSH_EN to add a synchronous flush input.
module handshake_fifo_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef HS_BUF_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       s_valid,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;
  logic             clear;

  // Status flags are pure decodes of the registered occupancy.
  assign s_ready     = (cnt_q != DEPTH_C);
  assign m_valid     = (cnt_q != '0);
  assign m_data      = mem[rd_ptr];
  assign count       = cnt_q;
  assign almost_full = (cnt_q >= AF_C);

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

`ifdef HS_BUF_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Storage, pointers and occupancy; rst beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset too so m_data reads a defined 0 after reset;
      // this costs a reset net on every entry, acceptable for a small buffer.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      // Contents stay in the array; they become unreachable once the
      // pointers are reset, and the same-cycle push is dropped.
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Self-checking bench for handshake_fifo_buffer (WIDTH=8, DEPTH=4).
// A queue-based model tracks expected contents; a negedge process compares
// every output each cycle, and directed sections pin literal values.
module tb_handshake_fifo_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [2:0]       count;
  logic             almost_full;
`ifdef HS_BUF_FLUSH_EN
  logic             flush = 1'b0;
`endif

  handshake_fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef HS_BUF_FLUSH_EN
    .flush       (flush),
`endif
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_ok = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] dut_out[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: a plain queue updated by the handshake rules.
  always @(posedge clk) begin
    int sz;
    bit push, pop;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_valid && m_ready) dut_out.push_back(m_data);
`ifdef HS_BUF_FLUSH_EN
      if (flush) begin
        exp_q.delete();
      end else begin
`endif
        push = s_valid && (sz != DEPTH);
        pop  = m_ready && (sz != 0);
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(s_data);
`ifdef HS_BUF_FLUSH_EN
      end
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("model count",   32'(count),       32'(exp_q.size()));
      check("model s_ready", 32'(s_ready),     32'(exp_q.size() != DEPTH));
      check("model m_valid", 32'(m_valid),     32'(exp_q.size() != 0));
      check("model almost",  32'(almost_full), 32'(exp_q.size() >= AF));
      if (exp_q.size() != 0)
        check("model m_data", 32'(m_data), 32'(exp_q[0]));
    end
  end

  // Apply inputs, let one edge pass, settle just after it.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (m_valid || exp_q.size() != 0); i++)
      step(1'b0, 8'h00, 1'b1);
    check("drain empty", 32'(m_valid), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] exp_order [5];
    exp_order[0] = 8'h01; exp_order[1] = 8'h02; exp_order[2] = 8'h03;
    exp_order[3] = 8'h04; exp_order[4] = 8'hFF;

    // 1: reset and idle
    #1;
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("rst s_ready", 32'(s_ready), 32'(1));
    check("rst m_valid", 32'(m_valid), 32'(0));
    check("rst m_data",  32'(m_data),  32'(8'h00));
    check("rst count",   32'(count),   32'(0));
    check("rst almost",  32'(almost_full), 32'(0));

    // 2: full-rate streaming
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b1);
      check("stream m_data",  32'(m_data),  32'(i));
      check("stream count",   32'(count),   32'(1));
      check("stream s_ready", 32'(s_ready), 32'(1));
    end
    drain();

    // 3: back-pressure up to full
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check("bp count",   32'(count),       32'(i));
      check("bp almost",  32'(almost_full), 32'(i >= 3));
      check("bp s_ready", 32'(s_ready),     32'(i != 4));
      check("bp m_data",  32'(m_data),      32'(8'h01));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      check("full hold count",  32'(count),  32'(4));
      check("full hold m_data", 32'(m_data), 32'(8'h01));
    end

    // 4: recovery, FF held on s_data until accepted
    dut_out.delete();
    step(1'b1, 8'hFF, 1'b1);
    check("recov s_ready", 32'(s_ready), 32'(1));
    check("recov count",   32'(count),   32'(3));
    step(1'b1, 8'hFF, 1'b1);
    check("recov push count", 32'(count), 32'(3));
    drain();
    check("recov out len", 32'(dut_out.size()), 32'(5));
    for (int i = 0; i < 5 && i < dut_out.size(); i++)
      check("recov order", 32'(dut_out[i]), 32'(exp_order[i]));

    // 5: random traffic, wraps pointers many times
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    drain();

    // 6: mid-operation reset with count=3
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    check("pre-rst count", 32'(count), 32'(3));
    rst = 1'b1;
    step(1'b1, 8'h55, 1'b1);
    rst = 1'b0;
    check("mid rst count",   32'(count),   32'(0));
    check("mid rst m_valid", 32'(m_valid), 32'(0));
    check("mid rst s_ready", 32'(s_ready), 32'(1));
    check("mid rst m_data",  32'(m_data),  32'(0));

`ifdef HS_BUF_FLUSH_EN
    dut_out.delete();
    for (int i = 0; i < 2; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    flush = 1'b1;
    step(1'b1, 8'hAA, 1'b0);
    flush = 1'b0;
    check("flush count",   32'(count),   32'(0));
    check("flush m_valid", 32'(m_valid), 32'(0));
    step(1'b1, 8'h5A, 1'b0);
    drain();
    check("flush out len", 32'(dut_out.size()), 32'(1));
    if (dut_out.size() != 0)
      check("flush no AA", 32'(dut_out[0]), 32'(8'h5A));
`endif

    step(1'b0, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
